// File: rtl/proc_io_host.sv
// Host-side I/O bridge for the floating-point processor: per-port input FIFOs feeding
// a one-hot read strobe, and a tagged output FIFO drained by the host over valid/ready.
module proc_io_host #(
    parameter int unsigned NUIOIN = 4,
    parameter int unsigned NUIOOU = 4,
    parameter int unsigned NBIN   = 19,
    parameter int unsigned NBOUT  = 28,
    parameter int unsigned IDEPTH = 2,
    parameter int unsigned ODEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [$clog2(NUIOIN)-1:0]  s_port,
    input  logic [NBIN-1:0]            s_data,
    input  logic [NUIOIN-1:0]          req_in,
    output logic [NBIN-1:0]            io_in,
    input  logic [NUIOOU-1:0]          out_en,
    input  logic [NBOUT-1:0]           io_out,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(NUIOOU)-1:0]  m_port,
    output logic [NBOUT-1:0]           m_data,
    input  logic                       clr_err,
    output logic [NUIOIN-1:0]          underrun,
    output logic                       overflow,
    output logic                       proto_err
);
    localparam int unsigned PWI = $clog2(NUIOIN);
    localparam int unsigned PWO = $clog2(NUIOOU);
    localparam int unsigned IAW = $clog2(IDEPTH);
    localparam int unsigned OAW = $clog2(ODEPTH);
    localparam logic [IAW:0] IPTR_ONE = (IAW+1)'(1);
    localparam logic [OAW:0] OPTR_ONE = (OAW+1)'(1);

    // Input path state
    logic [NBIN-1:0]   imem [NUIOIN][IDEPTH];
    logic [IAW:0]      iwp  [NUIOIN];
    logic [IAW:0]      irp  [NUIOIN];
    logic [NBIN-1:0]   last [NUIOIN];
    logic [NUIOIN-1:0] iempty, ifull;

    logic              s_push;
    logic              rd_hit, rd_pop, rd_multi;
    logic [PWI-1:0]    rd_sel;
    logic [NUIOIN-1:0] und_set;

    // Output path state
    logic [NBOUT-1:0]  odata [ODEPTH];
    logic [PWO-1:0]    oport [ODEPTH];
    logic [OAW:0]      owp, orp;
    logic              oempty, ofull;
    logic              o_req, o_push, o_pop, o_drop, wr_multi;
    logic [PWO-1:0]    wr_sel;

    always_comb begin
        for (int k = 0; k < int'(NUIOIN); k++) begin
            iempty[k] = (iwp[k] == irp[k]);
            ifull[k]  = (iwp[k][IAW] != irp[k][IAW]) &&
                        (iwp[k][IAW-1:0] == irp[k][IAW-1:0]);
        end
    end

    assign s_ready = !ifull[s_port];
    assign s_push  = s_valid & s_ready;

    // Lowest set bit of the read strobe wins
    always_comb begin
        rd_hit = 1'b0;
        rd_sel = '0;
        for (int i = int'(NUIOIN) - 1; i >= 0; i--) begin
            if (req_in[i]) begin
                rd_hit = 1'b1;
                rd_sel = PWI'(i);
            end
        end
    end

    assign rd_multi = |(req_in & (req_in - NUIOIN'(1)));
    assign rd_pop   = rd_hit & !iempty[rd_sel];

    always_comb begin
        io_in   = '0;
        und_set = '0;
        if (rd_hit) begin
            if (iempty[rd_sel]) begin
                io_in           = last[rd_sel];
                und_set[rd_sel] = 1'b1;
            end else begin
                io_in = imem[rd_sel][irp[rd_sel][IAW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s_push) imem[s_port][iwp[s_port][IAW-1:0]] <= s_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < int'(NUIOIN); k++) begin
                iwp[k]  <= '0;
                irp[k]  <= '0;
                last[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(NUIOIN); k++) begin
                if (s_push && s_port == PWI'(k)) iwp[k] <= iwp[k] + IPTR_ONE;
                if (rd_pop && rd_sel == PWI'(k)) begin
                    irp[k]  <= irp[k] + IPTR_ONE;
                    last[k] <= imem[k][irp[k][IAW-1:0]];
                end
            end
        end
    end

    // Output FIFO: write-side tag is the lowest set strobe bit
    always_comb begin
        wr_sel = '0;
        for (int i = int'(NUIOOU) - 1; i >= 0; i--) begin
            if (out_en[i]) wr_sel = PWO'(i);
        end
    end

    assign oempty   = (owp == orp);
    assign ofull    = (owp[OAW] != orp[OAW]) && (owp[OAW-1:0] == orp[OAW-1:0]);
    assign wr_multi = |(out_en & (out_en - NUIOOU'(1)));
    assign o_req    = |out_en;
    assign o_pop    = !oempty & m_ready;
    assign o_push   = o_req & (!ofull | o_pop);
    assign o_drop   = o_req & !o_push;

    // Head is gated to zero when empty so unwritten storage never leaks out
    assign m_valid = !oempty;
    assign m_port  = oempty ? '0 : oport[orp[OAW-1:0]];
    assign m_data  = oempty ? '0 : odata[orp[OAW-1:0]];

    always_ff @(posedge clk) begin
        if (o_push) begin
            odata[owp[OAW-1:0]] <= io_out;
            oport[owp[OAW-1:0]] <= wr_sel;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owp <= '0;
            orp <= '0;
        end else begin
            if (o_push) owp <= owp + OPTR_ONE;
            if (o_pop)  orp <= orp + OPTR_ONE;
        end
    end

    // Sticky flags; a new event in the clearing cycle keeps the flag set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underrun  <= '0;
            overflow  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            underrun  <= (clr_err ? '0   : underrun)  | und_set;
            overflow  <= (clr_err ? 1'b0 : overflow)  | o_drop;
            proto_err <= (clr_err ? 1'b0 : proto_err) | rd_multi | wr_multi;
        end
    end
endmodule

// File: tb/tb_proc_io_host.sv
// Directed bench for proc_io_host: input FIFOs, read mux, output FIFO, sticky flags, reset.
module tb_proc_io_host;
    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [1:0]  s_port;
    logic [18:0] s_data;
    logic [3:0]  req_in;
    logic [18:0] io_in;
    logic [3:0]  out_en;
    logic [27:0] io_out;
    logic        m_valid;
    logic        m_ready;
    logic [1:0]  m_port;
    logic [27:0] m_data;
    logic        clr_err;
    logic [3:0]  underrun;
    logic        overflow;
    logic        proto_err;

    int n_cmp = 0;
    int n_err = 0;

    proc_io_host dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_port(s_port), .s_data(s_data),
        .req_in(req_in), .io_in(io_in),
        .out_en(out_en), .io_out(io_out),
        .m_valid(m_valid), .m_ready(m_ready), .m_port(m_port), .m_data(m_data),
        .clr_err(clr_err), .underrun(underrun), .overflow(overflow), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] p, input logic [18:0] d);
        s_valid = 1'b1; s_port = p; s_data = d;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic clear_flags();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; s_valid = 0; s_port = 0; s_data = 0; req_in = 0;
        out_en = 0; io_out = 0; m_ready = 0; clr_err = 0;
        #12;
        n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL reset_s_ready: got %b exp 1", s_ready); end
        n_cmp++; if (io_in !== 19'h0) begin n_err++; $display("FAIL reset_io_in: got %h exp 0", io_in); end
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid: got %b exp 0", m_valid); end
        n_cmp++; if ({m_port, m_data} !== 30'h0) begin n_err++; $display("FAIL reset_m_head: got %h/%h exp 0/0", m_port, m_data); end
        n_cmp++; if ({underrun, overflow, proto_err} !== 6'h0) begin n_err++; $display("FAIL reset_flags: got %b%b%b exp 0", underrun, overflow, proto_err); end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic_read();
        push(2'd2, 19'h00123);
        req_in = 4'b0100;
        #1;
        n_cmp++; if (io_in !== 19'h00123) begin n_err++; $display("FAIL basic_io_in: got %h exp 00123", io_in); end
        tick();
        req_in = 4'b0000;
        n_cmp++; if (underrun !== 4'b0000) begin n_err++; $display("FAIL basic_underrun: got %b exp 0000", underrun); end
        // Port 2 now empty: a second read replays the last value and flags underrun
        req_in = 4'b0100;
        #1;
        n_cmp++; if (io_in !== 19'h00123) begin n_err++; $display("FAIL basic_replay: got %h exp 00123", io_in); end
        tick();
        req_in = 4'b0000;
        n_cmp++; if (underrun !== 4'b0100) begin n_err++; $display("FAIL basic_empty_flag: got %b exp 0100", underrun); end
        clear_flags();
    endtask

    task automatic test_full_and_simultaneous();
        push(2'd1, 19'd5);
        push(2'd1, 19'd7);
        s_port = 2'd1;
        #1;
        n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL full_s_ready: got %b exp 0", s_ready); end
        // Full: ready is evaluated before the pop, so this push of 9 is refused
        s_valid = 1'b1; s_data = 19'd9; req_in = 4'b0010;
        #1;
        n_cmp++; if (io_in !== 19'd5) begin n_err++; $display("FAIL full_read_head: got %h exp 5", io_in); end
        n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_before_pop: got %b exp 0", s_ready); end
        tick();
        s_valid = 1'b0; req_in = 4'b0000;
        n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL after_pop_ready: got %b exp 1", s_ready); end
        // Push and pop on the same port in one cycle
        s_valid = 1'b1; s_data = 19'd9; req_in = 4'b0010;
        #1;
        n_cmp++; if (io_in !== 19'd7) begin n_err++; $display("FAIL simul_read: got %h exp 7", io_in); end
        tick();
        s_valid = 1'b0;
        #1;
        n_cmp++; if (io_in !== 19'd9) begin n_err++; $display("FAIL simul_pushed: got %h exp 9", io_in); end
        tick();
        req_in = 4'b0000;
        n_cmp++; if (underrun !== 4'b0000) begin n_err++; $display("FAIL simul_underrun: got %b exp 0000", underrun); end
    endtask

    task automatic test_underrun();
        push(2'd0, 19'h7FFFF);
        req_in = 4'b0001;
        tick();
        #1;
        n_cmp++; if (io_in !== 19'h7FFFF) begin n_err++; $display("FAIL underrun_last: got %h exp 7ffff", io_in); end
        tick();
        req_in = 4'b0000;
        n_cmp++; if (underrun !== 4'b0001) begin n_err++; $display("FAIL underrun_set: got %b exp 0001", underrun); end
        clear_flags();
        n_cmp++; if (underrun !== 4'b0000) begin n_err++; $display("FAIL underrun_clr: got %b exp 0000", underrun); end
        // Clear and a new underrun together: set wins
        clr_err = 1'b1; req_in = 4'b0001;
        tick();
        clr_err = 1'b0; req_in = 4'b0000;
        n_cmp++; if (underrun !== 4'b0001) begin n_err++; $display("FAIL underrun_set_wins: got %b exp 0001", underrun); end
        clear_flags();
    endtask

    task automatic test_overflow();
        m_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            out_en = 4'b0001 << ((i - 1) % 4);
            io_out = 28'(i);
            tick();
            if (i == 1) begin
                n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL out_latency: got %b exp 1", m_valid); end
            end
        end
        out_en = 4'b0000;
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL overflow_set: got %b exp 1", overflow); end
        for (int i = 1; i <= 8; i++) begin
            n_cmp++;
            if (m_valid !== 1'b1 || m_port !== 2'((i - 1) % 4) || m_data !== 28'(i)) begin
                n_err++; $display("FAIL drain_%0d: got v=%b p=%0d d=%0d exp v=1 p=%0d d=%0d", i, m_valid, m_port, m_data, (i - 1) % 4, i);
            end
            m_ready = 1'b1;
            tick();
            m_ready = 1'b0;
        end
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %b exp 0", m_valid); end
        clear_flags();
        // Full FIFO with a pop and a push in the same cycle: nothing dropped
        for (int i = 11; i <= 18; i++) begin
            out_en = 4'b0010; io_out = 28'(i);
            tick();
        end
        out_en = 4'b0100; io_out = 28'd99; m_ready = 1'b1;
        tick();
        out_en = 4'b0000;
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL full_pop_push_overflow: got %b exp 0", overflow); end
        for (int i = 12; i <= 19; i++) begin
            n_cmp++;
            if (m_valid !== 1'b1 || m_port !== (i == 19 ? 2'd2 : 2'd1) || m_data !== (i == 19 ? 28'd99 : 28'(i))) begin
                n_err++; $display("FAIL full_pop_push_drain_%0d: got v=%b p=%0d d=%0d", i, m_valid, m_port, m_data);
            end
            tick();
        end
        m_ready = 1'b0;
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL full_pop_push_empty: got %b exp 0", m_valid); end
    endtask

    task automatic test_proto();
        push(2'd1, 19'h00042);
        push(2'd2, 19'h00055);
        req_in = 4'b0110;
        #1;
        n_cmp++; if (io_in !== 19'h00042) begin n_err++; $display("FAIL proto_sel_low: got %h exp 00042", io_in); end
        tick();
        req_in = 4'b0100;
        n_cmp++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL proto_req_multi: got %b exp 1", proto_err); end
        #1;
        n_cmp++; if (io_in !== 19'h00055) begin n_err++; $display("FAIL proto_port2_kept: got %h exp 00055", io_in); end
        tick();
        req_in = 4'b0000;
        clear_flags();
        out_en = 4'b1000; io_out = '1;
        tick();
        out_en = 4'b0101; io_out = 28'd3;
        n_cmp++; if (m_port !== 2'd3 || m_data !== 28'hFFFFFFF) begin n_err++; $display("FAIL proto_neg_out: got p=%0d d=%h exp p=3 d=fffffff", m_port, m_data); end
        n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL proto_single_hot: got %b exp 0", proto_err); end
        tick();
        out_en = 4'b0000;
        n_cmp++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL proto_out_multi: got %b exp 1", proto_err); end
        m_ready = 1'b1;
        tick();
        n_cmp++; if (m_port !== 2'd0 || m_data !== 28'd3) begin n_err++; $display("FAIL proto_out_low: got p=%0d d=%0d exp p=0 d=3", m_port, m_data); end
        tick();
        m_ready = 1'b0;
        clear_flags();
    endtask

    task automatic test_reset_mid();
        push(2'd3, 19'd1);
        s_valid = 1'b1; s_port = 2'd3; s_data = 19'd2; out_en = 4'b0001; io_out = 28'd5;
        tick();
        s_valid = 1'b0; out_en = 4'b0000;
        n_cmp++; if (s_ready !== 1'b0 || m_valid !== 1'b1) begin n_err++; $display("FAIL premid_state: got rdy=%b v=%b exp 0/1", s_ready, m_valid); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin n_err++; $display("FAIL async_reset: got v=%b rdy=%b exp 0/1", m_valid, s_ready); end
        #1;
        rst = 1'b1;
        req_in = 4'b1000;
        #1;
        n_cmp++; if (io_in !== 19'h0) begin n_err++; $display("FAIL reset_discard: got %h exp 0", io_in); end
        tick();
        req_in = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_full_and_simultaneous();
        test_underrun();
        test_overflow();
        test_proto();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
